mod_div_seq: RTL and testbench

Sequential restoring divider producing quotient and remainder of two unsigned W-bit operands, one quotient bit per clock. It is the clocked, parametrised successor to the combinational mod/div unit and feeds the modular-reduction step of the RSA modular-exponentiation datapath. A start/busy/done handshake replaces the combinational unrolled loop, so timing closes at any W. The partial remainder carries an extra sign bit to give correct results over the full operand range.

---
 rtl/mod_div_seq.sv | 139 +++++++++++++
 tb/tb_mod_div_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_div_seq.sv
// mod_div_seq: sequential restoring divider, unsigned W-bit operands, one quotient bit per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   dividend   numerator, captured when start is accepted
//   divisor    denominator, captured when start is accepted
//   busy       high whenever the divider is not idle
//   done       single-cycle pulse, quotient/remainder valid
//   quotient   registered quotient
//   remainder  registered remainder
//   div_zero   divisor-was-zero flag (only live with the zero-check option)
//
// Build option:
//   MOD_DIV_SEQ_ZERO_CHECK_EN  when defined, a zero divisor skips the iteration, finishes one
//                              cycle after start and raises div_zero. When undefined, div_zero
//                              is tied low and a zero divisor iterates normally (the restoring
//                              algorithm yields quotient all ones, remainder = dividend).

module mod_div_seq #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero
);

    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e          state_q;
    logic [W-1:0]    a_q;       // dividend shifting out, quotient bits shifting in
    logic [W-1:0]    n_q;       // captured divisor
    logic [W-1:0]    p_q;       // partial remainder
    logic [CntW-1:0] cnt_q;

    // The stored partial remainder is always below the divisor, so its extra sign bit is
    // always zero; only the shifted value and the trial difference need W+1 bits.
    logic [W:0]   p_shift;
    logic [W:0]   trial;
    logic [W-1:0] a_shift;
    logic [W-1:0] a_next;
    logic [W-1:0] p_next;

    always_comb begin
        p_shift = {p_q, a_q[W-1]};
        a_shift = {a_q[W-2:0], 1'b0};
        trial   = p_shift - {1'b0, n_q};
        a_next  = a_shift;
        p_next  = p_shift[W-1:0];
        if (!trial[W]) begin
            // Trial subtraction did not go negative: keep it and set the quotient bit.
            a_next = a_shift | W'(1);
            p_next = trial[W-1:0];
        end
    end

    assign busy = (state_q != StIdle);

`ifndef MOD_DIV_SEQ_ZERO_CHECK_EN
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            n_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef MOD_DIV_SEQ_ZERO_CHECK_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
`ifdef MOD_DIV_SEQ_ZERO_CHECK_EN
                    if (start && (divisor == '0)) begin
                        quotient  <= '1;
                        remainder <= dividend;
                        div_zero  <= 1'b1;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end else
`endif
                    if (start) begin
                        a_q     <= dividend;
                        n_q     <= divisor;
                        p_q     <= '0;
                        cnt_q   <= CntW'(W - 1);
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    a_q <= a_next;
                    p_q <= p_next;
                    if (cnt_q == '0) begin
                        // Results are loaded on the edge entering DONE so they appear with done.
                        quotient  <= a_next;
                        remainder <= p_next;
                        done      <= 1'b1;
`ifdef MOD_DIV_SEQ_ZERO_CHECK_EN
                        div_zero  <= 1'b0;
`endif
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_div_seq.sv
// tb_mod_div_seq: directed checks of mod_div_seq at W=16, plus operand sweeps at W=8 and W=32.

module tb_mod_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // W=16 instance
    logic        start;
    logic [15:0] dividend, divisor, quotient, remainder;
    logic        busy, done, div_zero;

    // W=8 instance
    logic       start8;
    logic [7:0] dividend8, divisor8, quotient8, remainder8;
    logic       busy8, done8, div_zero8;

    // W=32 instance
    logic        start32;
    logic [31:0] dividend32, divisor32, quotient32, remainder32;
    logic        busy32, done32, div_zero32;

    mod_div_seq #(.W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero)
    );

    mod_div_seq #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
        .div_zero(div_zero8)
    );

    mod_div_seq #(.W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .dividend(dividend32), .divisor(divisor32),
        .busy(busy32), .done(done32), .quotient(quotient32), .remainder(remainder32),
        .div_zero(div_zero32)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one W=16 operation, return start-to-done latency, then step past the done cycle.
    task automatic run16(input logic [15:0] dd, input logic [15:0] dv, output int lat);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        check("busy_rise", {63'd0, busy}, 64'd1);
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic after_done16();
        @(posedge clk); #1;
        check("done_pulse_low", {63'd0, done}, 64'd0);
        check("busy_fall", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          pulses;
        int          first_lat;
        logic [15:0] q_seen, r_seen;
        logic [7:0]  dd8, dv8;
        logic [31:0] dd32, dv32;
        int          t;

        rst_n      = 1'b0;
        start      = 1'b0;
        dividend   = 16'h0;
        divisor    = 16'h0;
        start8     = 1'b0;
        dividend8  = 8'h0;
        divisor8   = 8'h0;
        start32    = 1'b0;
        dividend32 = 32'h0;
        divisor32  = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);
        check("rst_quotient", {48'd0, quotient}, 64'd0);
        check("rst_remainder", {48'd0, remainder}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 100 / 7
        run16(16'd100, 16'd7, lat);
        check("lat_100_7", lat, 64'd17);
        check("q_100_7", {48'd0, quotient}, 64'd14);
        check("r_100_7", {48'd0, remainder}, 64'd2);
        check("dz_100_7", {63'd0, div_zero}, 64'd0);
        after_done16();
        check("hold_q_100_7", {48'd0, quotient}, 64'd14);

        run16(16'hFFFF, 16'h0001, lat);
        check("q_ffff_1", {48'd0, quotient}, 64'hFFFF);
        check("r_ffff_1", {48'd0, remainder}, 64'h0);
        after_done16();

        run16(16'hFFFF, 16'hFFFF, lat);
        check("q_ffff_ffff", {48'd0, quotient}, 64'h1);
        check("r_ffff_ffff", {48'd0, remainder}, 64'h0);
        after_done16();

        run16(16'h8000, 16'h8001, lat);
        check("q_8000_8001", {48'd0, quotient}, 64'h0);
        check("r_8000_8001", {48'd0, remainder}, 64'h8000);
        after_done16();

        // 5 / 9 with a second start (9 / 5) raised in CALC cycle 3; it must be ignored.
        dividend  = 16'd5;
        divisor   = 16'd9;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        pulses    = 0;
        first_lat = 0;
        q_seen    = 16'hDEAD;
        r_seen    = 16'hDEAD;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                dividend = 16'd9;
                divisor  = 16'd5;
                start    = 1'b1;
            end
            if (i == 3) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first_lat == 0) begin
                    first_lat = i + 1;
                    q_seen    = quotient;
                    r_seen    = remainder;
                end
            end
        end
        check("ign_pulses", pulses, 64'd1);
        check("ign_lat", first_lat, 64'd17);
        check("ign_q", {48'd0, q_seen}, 64'd0);
        check("ign_r", {48'd0, r_seen}, 64'd5);
        check("ign_q_hold", {48'd0, quotient}, 64'd0);
        check("ign_r_hold", {48'd0, remainder}, 64'd5);

        // Zero divisor
        run16(16'h1234, 16'h0000, lat);
`ifdef MOD_DIV_SEQ_ZERO_CHECK_EN
        check("lat_div0", lat, 64'd1);
        check("dz_div0", {63'd0, div_zero}, 64'd1);
`else
        check("lat_div0", lat, 64'd17);
        check("dz_div0", {63'd0, div_zero}, 64'd0);
`endif
        check("q_div0", {48'd0, quotient}, 64'hFFFF);
        check("r_div0", {48'd0, remainder}, 64'h1234);
        after_done16();

        // Nonzero divisor clears the flag
        run16(16'd1000, 16'd33, lat);
        check("q_1000_33", {48'd0, quotient}, 64'd30);
        check("r_1000_33", {48'd0, remainder}, 64'd10);
        check("dz_clear", {63'd0, div_zero}, 64'd0);
        after_done16();

        // Reset during CALC cycle 8
        dividend = 16'hFFFF;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_q", {48'd0, quotient}, 64'd0);
        check("mid_rst_r", {48'd0, remainder}, 64'd0);
        #2;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check("mid_rst_no_done", pulses, 64'd0);
        run16(16'd1000, 16'd33, lat);
        check("post_rst_lat", lat, 64'd17);
        check("post_rst_q", {48'd0, quotient}, 64'd30);
        check("post_rst_r", {48'd0, remainder}, 64'd10);
        after_done16();

        // W=8 sweep against reference arithmetic
        for (int k = 0; k < 500; k++) begin
            dd8       = 8'($urandom);
            dv8       = 8'($urandom_range(1, 255));
            dividend8 = dd8;
            divisor8  = dv8;
            start8    = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0;
            t      = 1;
            while (done8 !== 1'b1 && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            check("w8_done", {63'd0, done8}, 64'd1);
            check("w8_lat", t, 64'd9);
            check("w8_q", {56'd0, quotient8}, {56'd0, dd8 / dv8});
            check("w8_r", {56'd0, remainder8}, {56'd0, dd8 % dv8});
            @(posedge clk); #1;
        end

        // W=32 sweep, divisors of widely varying magnitude
        for (int k = 0; k < 500; k++) begin
            dd32 = $urandom;
            dv32 = $urandom >> $urandom_range(0, 31);
            if (dv32 == 32'd0) dv32 = 32'd1;
            dividend32 = dd32;
            divisor32  = dv32;
            start32    = 1'b1;
            @(posedge clk); #1;
            start32 = 1'b0;
            t       = 1;
            while (done32 !== 1'b1 && t < 80) begin
                @(posedge clk); #1;
                t++;
            end
            check("w32_done", {63'd0, done32}, 64'd1);
            check("w32_q", {32'd0, quotient32}, {32'd0, dd32 / dv32});
            check("w32_r", {32'd0, remainder32}, {32'd0, dd32 % dv32});
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
